// File: rtl/mixer_pkg.sv
// Purpose: shared types and widths for the IQ mixer (mode encoding, gain and counter widths).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mixer_pkg;

  // Mixer operating mode, captured per sample alongside in_valid.
  typedef enum logic {
    MODE_SIGN = 1'b0,   // 1-bit comparator: only the RF sign bit is used
    MODE_MULT = 1'b1    // full signed RF x LO multiply
  } mode_e;

  localparam int GAIN_W = 3;    // post-scale left shift amount, 0..7
  localparam int CNT_W  = 16;   // saturation event counter width

endpackage

// File: rtl/mixer_lane.sv
// Purpose: one LO channel of the mixer: product, round-half-up, gain shift, saturate.
// Latency: 2 cycles (product register, then output register); the caller's stage 1 makes 3 overall.
// Backpressure: none; each register loads only when its enable (upstream valid) is high, else holds.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   prod_en     stage-1 valid: load the product register
//   out_en      stage-2 valid: load mix/sat output registers
//   rf, lo      stage-1 RF sample and LO value (signed)
//   mode        stage-1 mode (sign or multiply)
//   gain        stage-2 gain, aligned with the product register
//   sat_nxt     saturation of the value about to be registered (for the counter)
//   mix, sat    registered lane output and its saturation flag
module mixer_lane
  import mixer_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int RF_WIDTH = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                prod_en,
  input  logic                out_en,
  input  logic [RF_WIDTH-1:0] rf,
  input  logic [WIDTH-1:0]    lo,
  input  mode_e               mode,
  input  logic [GAIN_W-1:0]   gain,
  output logic                sat_nxt,
  output logic [WIDTH-1:0]    mix,
  output logic                sat
);

  // A full signed RF x LO product always fits in RF_WIDTH+WIDTH bits,
  // including the -2^(W-1) x -2^(R-1) corner.
  localparam int PW = RF_WIDTH + WIDTH;
  // Headroom: one bit for the rounding add, 2^GAIN_W-1 bits for the gain shift.
  localparam int EW = PW + (1 << GAIN_W);
  localparam int SH = RF_WIDTH - 1;
  // Half an LSB of the divided result; zero when there is no division (RF_WIDTH=1).
  localparam logic signed [EW-1:0] HALF = EW'((2 ** SH) >> 1);

  logic signed [PW-1:0] rf_x, lo_x, lo_sh, prod_d, prod_q;
  logic signed [EW-1:0] prod_e, rnd, scl;
  logic                 fits;
  logic [WIDTH-1:0]     mix_d;

  assign rf_x  = {{WIDTH{rf[RF_WIDTH-1]}}, rf};
  assign lo_x  = {{RF_WIDTH{lo[WIDTH-1]}}, lo};
  assign lo_sh = lo_x <<< SH;

  // Sign mode treats the RF sample as +/- full scale, so the LO is simply
  // scaled by 2^(RF_WIDTH-1) and negated when the RF sign bit is set.
  always_comb begin
    prod_d = '0;
    if (mode == MODE_MULT) prod_d = rf_x * lo_x;
    else if (rf[RF_WIDTH-1]) prod_d = -lo_sh;
    else prod_d = lo_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= '0;
    else if (prod_en) prod_q <= prod_d;
  end

  // Arithmetic shift right after adding half gives round-half-up (toward +inf).
  always_comb begin
    prod_e  = {{(EW-PW){prod_q[PW-1]}}, prod_q};
    rnd     = (prod_e + HALF) >>> SH;
    scl     = rnd <<< gain;
    // In range iff every bit above the output sign bit matches it.
    fits    = (&scl[EW-1:WIDTH-1]) | ~(|scl[EW-1:WIDTH-1]);
    sat_nxt = ~fits;
    mix_d   = scl[WIDTH-1:0];
    if (!fits) mix_d = scl[EW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix <= '0;
      sat <= 1'b0;
    end else if (out_en) begin
      mix <= mix_d;
      sat <= sat_nxt;
    end
  end

endmodule

// File: rtl/mixer_iq.sv
// Purpose: IQ mixer: multiplies (or sign-mixes) an RF sample by LO sine and cosine, with saturation count.
// Latency: 3 cycles in_valid -> out_valid in both modes; rf_out is a free-running RF_DELAY-cycle delay.
// Backpressure: none; gaps in in_valid propagate as out_valid gaps and stage data holds across them.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid                   strobe for rf_in, sin_in, cos_in, mode, gain
//   rf_in, sin_in, cos_in      signed RF sample and LO sine/cosine
//   mode, gain                 0=sign / 1=multiply; post-scale left shift 0..7
//   clr_count                  synchronous clear of sat_count (wins over increment)
//   rf_out                     rf_in delayed RF_DELAY cycles
//   out_valid, mix_sin, mix_cos, sat_flag   mixer outputs (hold when not valid)
//   sat_count                  saturating count of saturated output samples
module mixer_iq
  import mixer_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int RF_WIDTH = 12,
  parameter int RF_DELAY = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [RF_WIDTH-1:0] rf_in,
  input  logic [WIDTH-1:0]    sin_in,
  input  logic [WIDTH-1:0]    cos_in,
  input  logic                mode,
  input  logic [GAIN_W-1:0]   gain,
  input  logic                clr_count,
  output logic [RF_WIDTH-1:0] rf_out,
  output logic                out_valid,
  output logic [WIDTH-1:0]    mix_sin,
  output logic [WIDTH-1:0]    mix_cos,
  output logic                sat_flag,
  output logic [CNT_W-1:0]    sat_count
);

  // Stage 1: input capture.
  logic                v1;
  logic [RF_WIDTH-1:0] rf_q;
  logic [WIDTH-1:0]    sin_q, cos_q;
  mode_e               mode_q;
  logic [GAIN_W-1:0]   gain_q1;
  // Stage 2: valid and gain travel alongside the lane product registers.
  logic                v2;
  logic [GAIN_W-1:0]   gain_q2;

  logic                sat_nxt_s, sat_nxt_c, sat_s, sat_c;
  logic                sat_inc;
  logic [RF_WIDTH-1:0] rf_dly [RF_DELAY];

  // Valid bits always shift; data registers load only behind a valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      rf_q      <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      mode_q    <= MODE_SIGN;
      gain_q1   <= '0;
      gain_q2   <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        rf_q    <= rf_in;
        sin_q   <= sin_in;
        cos_q   <= cos_in;
        mode_q  <= mode_e'(mode);
        gain_q1 <= gain;
      end
      if (v1) gain_q2 <= gain_q1;
    end
  end

  mixer_lane #(.WIDTH(WIDTH), .RF_WIDTH(RF_WIDTH)) u_lane_sin (
    .clk     (clk),
    .rst_n   (rst_n),
    .prod_en (v1),
    .out_en  (v2),
    .rf      (rf_q),
    .lo      (sin_q),
    .mode    (mode_q),
    .gain    (gain_q2),
    .sat_nxt (sat_nxt_s),
    .mix     (mix_sin),
    .sat     (sat_s)
  );

  mixer_lane #(.WIDTH(WIDTH), .RF_WIDTH(RF_WIDTH)) u_lane_cos (
    .clk     (clk),
    .rst_n   (rst_n),
    .prod_en (v1),
    .out_en  (v2),
    .rf      (rf_q),
    .lo      (cos_q),
    .mode    (mode_q),
    .gain    (gain_q2),
    .sat_nxt (sat_nxt_c),
    .mix     (mix_cos),
    .sat     (sat_c)
  );

  // Both lane flags are registers loaded on the same edge as the mix outputs.
  assign sat_flag = sat_s | sat_c;

  // Count on the edge the saturated sample is registered, so sat_count is
  // already updated when that sample is presented.
  assign sat_inc = v2 & (sat_nxt_s | sat_nxt_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (clr_count) sat_count <= '0;
    else if (sat_inc && (sat_count != {CNT_W{1'b1}})) sat_count <= sat_count + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DELAY; i++) rf_dly[i] <= '0;
    end else begin
      rf_dly[0] <= rf_in;
      for (int i = 1; i < RF_DELAY; i++) rf_dly[i] <= rf_dly[i-1];
    end
  end

  assign rf_out = rf_dly[RF_DELAY-1];

endmodule

// File: tb/tb_mixer_iq.sv
// Purpose: self-checking bench for mixer_iq with directed vectors and a scoreboard monitor.
// Latency: expects out_valid exactly 3 cycles after each accepted in_valid.
// Backpressure: n/a (DUT has none); stimulus includes in_valid gaps and a mid-stream reset.
module tb_mixer_iq;
  localparam int W  = 12;
  localparam int RW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [RW-1:0] rf_in = '0;
  logic [W-1:0]  sin_in = '0;
  logic [W-1:0]  cos_in = '0;
  logic          mode = 1'b0;
  logic [2:0]    gain = '0;
  logic          clr_count = 1'b0;
  logic [RW-1:0] rf_out;
  logic          out_valid;
  logic [W-1:0]  mix_sin, mix_cos;
  logic          sat_flag;
  logic [15:0]   sat_count;

  mixer_iq #(.WIDTH(W), .RF_WIDTH(RW), .RF_DELAY(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .rf_in     (rf_in),
    .sin_in    (sin_in),
    .cos_in    (cos_in),
    .mode      (mode),
    .gain      (gain),
    .clr_count (clr_count),
    .rf_out    (rf_out),
    .out_valid (out_valid),
    .mix_sin   (mix_sin),
    .mix_cos   (mix_cos),
    .sat_flag  (sat_flag),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] c;
    logic         f;
    int           cy;
  } exp_t;
  exp_t q[$];

  typedef struct {
    int rf; int s; int c; logic m; int g; int es; int ec; logic ef;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every presented output must match the oldest expectation, on time.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: out_valid with empty scoreboard, got 0x%0h expected none (cycle %0d)",
                 {mix_sin, mix_cos, sat_flag}, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mix_data", {7'b0, mix_sin, mix_cos, sat_flag}, {7'b0, e.s, e.c, e.f});
        check("out_timing", cyc, e.cy);
      end
    end
  end

  // Called just after a rising edge; the sample is accepted on the next edge.
  task automatic send(input vec_t v, input logic expect_it);
    exp_t e;
    in_valid = 1'b1;
    rf_in    = v.rf[RW-1:0];
    sin_in   = v.s[W-1:0];
    cos_in   = v.c[W-1:0];
    mode     = v.m;
    gain     = v.g[2:0];
    e.s  = v.es[W-1:0];
    e.c  = v.ec[W-1:0];
    e.f  = v.ef;
    e.cy = cyc + 3;
    if (expect_it) q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    check("drain_empty", q.size(), 0);
  endtask

  vec_t tbl[10];
  vec_t vsat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //          rf      sin    cos    m     g  exp_s  exp_c  f
    tbl[0] = '{'h001,   100,  -200, 1'b0, 0,   100,  -200, 1'b0};
    tbl[1] = '{'h800,   100,  -200, 1'b0, 0,  -100,   200, 1'b0};
    tbl[2] = '{'h800, -2048,     0, 1'b0, 0,  2047,     0, 1'b1};
    tbl[3] = '{1024,   1000, -1000, 1'b1, 0,   500,  -500, 1'b0};
    tbl[4] = '{1024,   1000, -1000, 1'b1, 2,  2000, -2000, 1'b0};
    tbl[5] = '{1024,   1000, -1000, 1'b1, 3,  2047, -2048, 1'b1};
    tbl[6] = '{1,      1024, -1024, 1'b1, 0,     1,     0, 1'b0};
    tbl[7] = '{1,      1023,     0, 1'b1, 0,     0,     0, 1'b0};
    tbl[8] = '{'h800, -2048,  2047, 1'b1, 0,  2047, -2047, 1'b1};
    tbl[9] = '{'h7FF, -2048,  2047, 1'b0, 1, -2048,  2047, 1'b1};
    vsat   = '{'h800, -2048, -2048, 1'b0, 0,  2047,  2047, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_mix_sin", mix_sin, 0);
    check("rst_mix_cos", mix_cos, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_rf_out", rf_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors; a gap after the first gives the 1,0,1,1 valid pattern.
    for (int i = 0; i < 10; i++) begin
      send(tbl[i], 1'b1);
      if (i == 0) idle(1);
    end
    drain();
    check("sat_count_4", sat_count, 4);
    check("hold_mix_sin", mix_sin, 12'h800);
    check("hold_mix_cos", mix_cos, 12'h7FF);
    check("hold_sat_flag", sat_flag, 1);
    check("idle_out_valid", out_valid, 0);

    // rf_out runs regardless of in_valid.
    rf_in = 12'h5A5;
    @(posedge clk); #1;
    check("rf_out_delay", rf_out, 12'h5A5);

    // Reset with two samples in flight: everything clears at once, nothing stale emerges.
    send(tbl[3], 1'b0);
    send(tbl[4], 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_mix_sin", mix_sin, 0);
    check("midrst_mix_cos", mix_cos, 0);
    check("midrst_sat_flag", sat_flag, 0);
    check("midrst_sat_count", sat_count, 0);
    check("midrst_rf_out", rf_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(tbl[3], 1'b1);
    drain();
    check("post_rst_count", sat_count, 0);

    // Saturate the counter.
    for (int i = 0; i < 65537; i++) send(vsat, 1'b1);
    drain();
    check("sat_count_max", sat_count, 16'hFFFF);
    send(vsat, 1'b1);
    drain();
    check("sat_count_nowrap", sat_count, 16'hFFFF);

    // Clear coinciding with a saturated sample's increment edge.
    send(vsat, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    check("clr_wins", sat_count, 0);
    drain();

    // Plain increment then plain clear.
    send(vsat, 1'b1);
    drain();
    check("count_one", sat_count, 1);
    clr_count = 1'b1;
    @(posedge clk); #1;
    clr_count = 1'b0;
    check("clr_alone", sat_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mixer_iq.md
MIXER_IQ -- requirements
Module: mixer_iq

Interface
REQ-001 SHALL have parameter WIDTH, default 12: LO (sin/cos) input and mixer output width in bits, range 8..18.
REQ-002 SHALL have parameter RF_WIDTH, default 12: signed RF sample width, range 1..16.
REQ-003 SHALL have parameter RF_DELAY, default 1: rf_out delay in cycles, range 1..8.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports (clock and reset first):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe for rf_in, sin_in, cos_in, mode, gain
- rf_in  in  RF_WIDTH  signed RF sample
- sin_in  in  WIDTH  signed LO sine
- cos_in  in  WIDTH  signed LO cosine
- mode  in  1  0 = sign (1-bit comparator) mode, 1 = full multiply
- gain  in  3  post-scale left shift, 0..7
- clr_count  in  1  synchronous clear of sat_count
- rf_out  out  RF_WIDTH  rf_in delayed RF_DELAY cycles
- out_valid  out  1  mix outputs valid
- mix_sin  out  WIDTH  signed mixed sine product
- mix_cos  out  WIDTH  signed mixed cosine product
- sat_flag  out  1  current output sample saturated on either lane
- sat_count  out  16  count of saturated output samples

Function
REQ-006 SHALL be a 3-stage pipeline: stage 1 registers inputs, stage 2 forms product, stage 3 rounds, scales, saturates; out_valid equals in_valid delayed exactly 3 cycles in both modes.
REQ-007 Sign mode: product SHALL be +LO × 2^(RF_WIDTH-1) when rf_in MSB = 0, -LO × 2^(RF_WIDTH-1) when MSB = 1; remaining rf_in bits ignored.
REQ-008 Multiply mode: product SHALL be the full signed rf_in × LO product, RF_WIDTH+WIDTH bits, no truncation.
REQ-009 Stage 3 SHALL compute round-half-up(product / 2^(RF_WIDTH-1)), then shift left by gain, then saturate to signed WIDTH range [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-010 Negation of -2^(WIDTH-1) in sign mode SHALL yield +2^(WIDTH-1)-1 with sat_flag = 1.
REQ-011 mode and gain SHALL be captured per sample with in_valid; a change affects only samples presented after it, with no pipeline flush.
REQ-012 When in_valid = 0, pipeline stages SHALL hold their data; out_valid goes low 3 cycles later; mix_sin, mix_cos, and sat_flag hold their last valid values.
REQ-013 sat_flag SHALL be registered with mix_sin and mix_cos and is meaningful only while out_valid = 1.
REQ-014 sat_count SHALL increment by 1 on each out_valid sample with sat_flag = 1 and saturate at 0xFFFF without wrapping.
REQ-015 clr_count SHALL set sat_count to 0 on the next edge; when a clear and an increment coincide, the clear wins and the result is 0.
REQ-016 rf_out SHALL be a free-running RF_DELAY-stage shift register, independent of in_valid.

Reset
REQ-017 On rst_n low, all pipeline valid bits, out_valid, mix_sin, mix_cos, sat_flag, sat_count, and every rf_out stage SHALL clear to 0 immediately (asynchronously).
REQ-018 Samples in flight when reset asserts SHALL be discarded; the first out_valid after release SHALL occur 3 cycles after the first accepted in_valid.

Structure
REQ-019 SHALL have package mixer_pkg containing the mode enum (MODE_SIGN, MODE_MULT), the gain width constant, and the sat_count width constant.
REQ-020 SHALL implement one sub-module, mixer_lane (product, round, scale, saturate for one LO channel), instantiated twice for sin and cos; valid pipeline, rf_out delay, and counter SHALL reside in mixer_iq.

Verification (WIDTH=12, RF_WIDTH=12)
REQ-021 Sign mode, gain 0: rf=0x001, sin=100, cos=-200 -> after 3 cycles mix_sin=100, mix_cos=-200; rf=0x800 -> mix_sin=-100, mix_cos=200; sat_flag=0.
REQ-022 Sign mode: rf=0x800, sin=-2048 -> mix_sin=2047, sat_flag=1, sat_count=1.
REQ-023 Multiply mode: rf=1024, sin=1000, cos=-1000, gain 0 -> mix_sin=500, mix_cos=-500; gain 2 -> 2000; gain 3 -> mix_sin=2047, mix_cos=-2048, sat_flag=1.
REQ-024 Rounding: multiply mode, rf=1, sin=1024 -> 1; sin=-1024 -> 0; sin=1023 -> 0.
REQ-025 Stream with in_valid pattern 1,0,1,1 and rst_n pulsed low mid-stream -> out_valid pattern matches input delayed 3 cycles, all outputs 0 immediately on reset, no stale sample after release.
REQ-026 Force 65537 saturated samples -> sat_count=0xFFFF; clr_count coincident with a saturated sample -> sat_count=0.
